// File: rtl/c2h_stream_arb.sv
// Round-robin N:1 AXI-Stream packet arbiter for a shared C2H channel, with a packet counter.
// Optional packet-count interrupt enabled by defining C2H_ARB_IRQ_EN.
module c2h_stream_arb #(
  parameter int TCQ             = 1,
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH/8,
  parameter int NUM_SRC         = 4,
  parameter int IRQ_PKT_CNT     = 16
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      s_axis_src_tdata,
  input  logic [NUM_SRC*BYTE_BIT_ENABLE-1:0] s_axis_src_tkeep,
  input  logic [NUM_SRC-1:0]                 s_axis_src_tlast,
  input  logic [NUM_SRC-1:0]                 s_axis_src_tvalid,
  output logic [NUM_SRC-1:0]                 s_axis_src_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_c2h_tdata,
  output logic [BYTE_BIT_ENABLE-1:0]         m_axis_c2h_tkeep,
  output logic                               m_axis_c2h_tlast,
  output logic                               m_axis_c2h_tvalid,
  input  logic                               m_axis_c2h_tready,
  output logic [1:0]                         grant_id,
  output logic [31:0]                        pkt_total,
  output logic                               irq_req,
  input  logic                               irq_ack
);

  // TCQ is kept for interface compatibility only; registered paths carry no delay.
  if (NUM_SRC < 2 || NUM_SRC > 4 || IRQ_PKT_CNT < 1 || IRQ_PKT_CNT > 65535 || TCQ < 0) begin : g_bad_param
    $error("c2h_stream_arb: parameter out of legal range");
  end

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_grant_id;
  logic [31:0] r_pkt_total;
  logic [3:0]  w_req;
  logic        w_found;
  logic [1:0]  w_pick;
  logic        w_done;

  always_comb begin
    w_req = '0;
    w_req[NUM_SRC-1:0] = s_axis_src_tvalid;
  end

  // Search starts one past the last grant and wraps at NUM_SRC; the last grant itself is checked last.
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = r_grant_id;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      v_idx = (32'(r_grant_id) + i) % NUM_SRC;
      if (!w_found && w_req[v_idx[1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_idx[1:0];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = XFER;
      XFER:    if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_c2h_tdata  = '0;
    m_axis_c2h_tkeep  = '0;
    m_axis_c2h_tlast  = 1'b0;
    m_axis_c2h_tvalid = 1'b0;
    s_axis_src_tready = '0;
    if (r_state == XFER) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (r_grant_id == 2'(k)) begin
          m_axis_c2h_tdata     = s_axis_src_tdata[k*DATA_WIDTH +: DATA_WIDTH];
          m_axis_c2h_tkeep     = s_axis_src_tkeep[k*BYTE_BIT_ENABLE +: BYTE_BIT_ENABLE];
          m_axis_c2h_tlast     = s_axis_src_tlast[k];
          m_axis_c2h_tvalid    = s_axis_src_tvalid[k];
          s_axis_src_tready[k] = m_axis_c2h_tready;
        end
      end
    end
  end

  assign w_done = (r_state == XFER) && m_axis_c2h_tvalid && m_axis_c2h_tready && m_axis_c2h_tlast;

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      r_grant_id  <= 2'(NUM_SRC-1);
      r_pkt_total <= '0;
    end else begin
      if (r_state == IDLE && w_found) r_grant_id <= w_pick;
      if (w_done) r_pkt_total <= r_pkt_total + 32'd1;
    end
  end

  assign grant_id  = r_grant_id;
  assign pkt_total = r_pkt_total;

`ifdef C2H_ARB_IRQ_EN
  logic [15:0] r_irq_cnt;
  logic        r_irq_req;
  logic        w_irq_hit;

  assign w_irq_hit = w_done && (r_irq_cnt == 16'(IRQ_PKT_CNT-1));

  // A threshold hit wins over a simultaneous ack; further hits while pending coalesce.
  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      r_irq_cnt <= '0;
      r_irq_req <= 1'b0;
    end else begin
      if (w_irq_hit)   r_irq_cnt <= '0;
      else if (w_done) r_irq_cnt <= r_irq_cnt + 16'd1;
      if (w_irq_hit)    r_irq_req <= 1'b1;
      else if (irq_ack) r_irq_req <= 1'b0;
    end
  end

  assign irq_req = r_irq_req;
`else
  logic w_irq_ack_unused;
  assign w_irq_ack_unused = irq_ack;
  assign irq_req = 1'b0;
`endif

endmodule

// File: tb/tb_c2h_stream_arb.sv
// Directed self-checking bench for c2h_stream_arb: reset, single packet, round-robin,
// stall/bubble, mid-packet reset and the interrupt (either build of C2H_ARB_IRQ_EN).
module tb_c2h_stream_arb;
  localparam int DW   = 128;
  localparam int KW   = 16;
  localparam int NS   = 4;
  localparam int IRQN = 3;

  logic               user_clk = 1'b0;
  logic               user_rst;
  logic [NS*DW-1:0]   s_axis_src_tdata;
  logic [NS*KW-1:0]   s_axis_src_tkeep;
  logic [NS-1:0]      s_axis_src_tlast;
  logic [NS-1:0]      s_axis_src_tvalid;
  logic [NS-1:0]      s_axis_src_tready;
  logic [DW-1:0]      m_axis_c2h_tdata;
  logic [KW-1:0]      m_axis_c2h_tkeep;
  logic               m_axis_c2h_tlast;
  logic               m_axis_c2h_tvalid;
  logic               m_axis_c2h_tready;
  logic [1:0]         grant_id;
  logic [31:0]        pkt_total;
  logic               irq_req;
  logic               irq_ack;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_total = '0;

  always #5 user_clk = ~user_clk;

  c2h_stream_arb #(
    .TCQ(1), .DATA_WIDTH(DW), .BYTE_BIT_ENABLE(KW), .NUM_SRC(NS), .IRQ_PKT_CNT(IRQN)
  ) dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .s_axis_src_tdata(s_axis_src_tdata), .s_axis_src_tkeep(s_axis_src_tkeep),
    .s_axis_src_tlast(s_axis_src_tlast), .s_axis_src_tvalid(s_axis_src_tvalid),
    .s_axis_src_tready(s_axis_src_tready),
    .m_axis_c2h_tdata(m_axis_c2h_tdata), .m_axis_c2h_tkeep(m_axis_c2h_tkeep),
    .m_axis_c2h_tlast(m_axis_c2h_tlast), .m_axis_c2h_tvalid(m_axis_c2h_tvalid),
    .m_axis_c2h_tready(m_axis_c2h_tready),
    .grant_id(grant_id), .pkt_total(pkt_total), .irq_req(irq_req), .irq_ack(irq_ack)
  );

  function automatic logic [DW-1:0] pat(input int k, input int b);
    return {8'(k), 8'(b), 112'h0123456789ABCDEF0123456789AB};
  endfunction

  function automatic logic [KW-1:0] keep(input bit last);
    return last ? 16'h00FF : 16'hFFFF;
  endfunction

  task automatic drive_src(input int k, input bit v, input int b, input bit last);
    s_axis_src_tdata[k*DW +: DW] = pat(k, b);
    s_axis_src_tkeep[k*KW +: KW] = keep(last);
    s_axis_src_tlast[k]          = last;
    s_axis_src_tvalid[k]         = v;
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_rst          = 1'b0;
    s_axis_src_tvalid = '0;
    s_axis_src_tlast  = '0;
    irq_ack           = 1'b0;
    exp_total         = '0;
    @(negedge user_clk);
    user_rst = 1'b1;
  endtask

  // Runs one packet of n beats from source k; optionally holds irq_ack high during the last beat.
  task automatic send_packet(input int k, input int n, input bit ack_last);
    int b    = 0;
    bit done = 1'b0;
    bit fire;
    step();
    drive_src(k, 1'b1, 0, n == 1);
    if (ack_last && n == 1) irq_ack = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge user_clk);
      fire = s_axis_src_tready[k];
      step();
      if (fire) begin
        if (b == n-1) begin
          done = 1'b1;
          drive_src(k, 1'b0, 0, 1'b0);
          irq_ack   = 1'b0;
          exp_total = exp_total + 32'd1;
        end else begin
          b++;
          drive_src(k, 1'b1, b, b == n-1);
          if (ack_last && b == n-1) irq_ack = 1'b1;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_packet src %0d: completed=%0d required=1", k, done);
    end
  endtask

  task automatic test_reset();
    user_rst          = 1'b0;
    s_axis_src_tdata  = '0;
    s_axis_src_tkeep  = '0;
    s_axis_src_tlast  = '0;
    s_axis_src_tvalid = '0;
    m_axis_c2h_tready = 1'b1;
    irq_ack           = 1'b0;
    #12;
    checks++;
    if (grant_id !== 2'd3 || pkt_total !== 32'd0 || irq_req !== 1'b0 ||
        m_axis_c2h_tvalid !== 1'b0 || s_axis_src_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset: grant=%0d total=%0d irq=%b tvalid=%b tready=%b required 3 0 0 0 0000",
               grant_id, pkt_total, irq_req, m_axis_c2h_tvalid, s_axis_src_tready);
    end
    @(negedge user_clk);
    user_rst = 1'b1;
  endtask

  task automatic test_single();
    step();
    drive_src(0, 1'b1, 0, 1'b0);
    @(negedge user_clk);
    checks++;
    if (m_axis_c2h_tvalid !== 1'b0 || s_axis_src_tready !== 4'b0000) begin
      errors++;
      $display("FAIL single_latency: tvalid=%b tready=%b required 0 0000", m_axis_c2h_tvalid, s_axis_src_tready);
    end
    step();
    for (int b = 0; b < 4; b++) begin
      @(negedge user_clk);
      checks++;
      if (grant_id !== 2'd0 || m_axis_c2h_tvalid !== 1'b1 || m_axis_c2h_tdata !== pat(0, b) ||
          m_axis_c2h_tkeep !== keep(b == 3) || m_axis_c2h_tlast !== (b == 3) || s_axis_src_tready !== 4'b0001) begin
        errors++;
        $display("FAIL single_beat%0d: grant=%0d data=%h last=%b tready=%b required 0 %h %b 0001",
                 b, grant_id, m_axis_c2h_tdata, m_axis_c2h_tlast, s_axis_src_tready, pat(0, b), b == 3);
      end
      step();
      if (b < 3) drive_src(0, 1'b1, b+1, (b+1) == 3);
      else       drive_src(0, 1'b0, 0, 1'b0);
    end
    exp_total = exp_total + 32'd1;
    @(negedge user_clk);
    checks++;
    if (m_axis_c2h_tvalid !== 1'b0 || pkt_total !== exp_total) begin
      errors++;
      $display("FAIL single_done: tvalid=%b total=%0d required 0 %0d", m_axis_c2h_tvalid, pkt_total, exp_total);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int cnt   [4] = '{0, 0, 0, 0};
    int pkt       = 0;
    int idle      = 0;
    int g         = 0;
    bit fire;
    bit prev_last = 1'b0;
    do_reset();
    step();
    for (int k = 0; k < 4; k++) drive_src(k, 1'b1, 0, 1'b0);
    for (int c = 0; c < 60 && pkt < 5; c++) begin
      @(negedge user_clk);
      fire = 1'b0;
      if (m_axis_c2h_tvalid) begin
        g = order[pkt];
        checks++;
        if (prev_last || grant_id !== 2'(g) || s_axis_src_tready !== 4'(1 << g) ||
            m_axis_c2h_tdata !== pat(g, cnt[g]) || m_axis_c2h_tlast !== (cnt[g] == 1)) begin
          errors++;
          $display("FAIL rr_pkt%0d: gap_missing=%b grant=%0d tready=%b data=%h required grant %0d beat %0d",
                   pkt, prev_last, grant_id, s_axis_src_tready, m_axis_c2h_tdata, g, cnt[g]);
        end
        fire = 1'b1;
      end else begin
        idle++;
      end
      prev_last = fire && m_axis_c2h_tlast;
      step();
      if (fire) begin
        if (cnt[g] == 1) begin
          cnt[g]    = 0;
          pkt++;
          exp_total = exp_total + 32'd1;
          if (pkt == 5) s_axis_src_tvalid = '0;
          else          drive_src(g, 1'b1, 0, 1'b0);
        end else begin
          cnt[g] = 1;
          drive_src(g, 1'b1, 1, 1'b1);
        end
      end
    end
    @(negedge user_clk);
    checks++;
    if (pkt != 5 || idle != 5 || pkt_total !== exp_total) begin
      errors++;
      $display("FAIL rr_summary: packets=%0d idle=%0d total=%0d required 5 5 %0d", pkt, idle, pkt_total, exp_total);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    step();
    drive_src(1, 1'b1, 0, 1'b0);
    drive_src(2, 1'b1, 0, 1'b0);
    step();
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd1 || s_axis_src_tready !== 4'b0010 || m_axis_c2h_tdata !== pat(1, 0)) begin
      errors++;
      $display("FAIL stall_grant: grant=%0d tready=%b required 1 0010", grant_id, s_axis_src_tready);
    end
    step();
    drive_src(1, 1'b1, 1, 1'b0);
    m_axis_c2h_tready = 1'b0;
    @(negedge user_clk);
    held = m_axis_c2h_tdata;
    checks++;
    if (held !== pat(1, 1) || s_axis_src_tready !== 4'b0000) begin
      errors++;
      $display("FAIL stall_low: data=%h tready=%b required %h 0000", held, s_axis_src_tready, pat(1, 1));
    end
    step();
    m_axis_c2h_tready = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_axis_c2h_tdata !== pat(1, 1) || grant_id !== 2'd1 || s_axis_src_tready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_resume: data=%h grant=%0d tready=%b required %h 1 0010",
               m_axis_c2h_tdata, grant_id, s_axis_src_tready, pat(1, 1));
    end
    step();
    drive_src(1, 1'b1, 2, 1'b1);
    @(negedge user_clk);
    checks++;
    if (m_axis_c2h_tlast !== 1'b1 || s_axis_src_tready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_last: tlast=%b tready=%b required 1 0010", m_axis_c2h_tlast, s_axis_src_tready);
    end
    step();
    drive_src(1, 1'b0, 0, 1'b0);
    exp_total = exp_total + 32'd1;
    @(negedge user_clk);
    checks++;
    if (m_axis_c2h_tvalid !== 1'b0 || s_axis_src_tready !== 4'b0000) begin
      errors++;
      $display("FAIL stall_gap: tvalid=%b tready=%b required 0 0000", m_axis_c2h_tvalid, s_axis_src_tready);
    end
    step();
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd2 || s_axis_src_tready !== 4'b0100 || m_axis_c2h_tdata !== pat(2, 0)) begin
      errors++;
      $display("FAIL stall_next: grant=%0d tready=%b required 2 0100", grant_id, s_axis_src_tready);
    end
    step();
    drive_src(2, 1'b0, 1, 1'b1);
    drive_src(0, 1'b1, 0, 1'b1);
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd2 || m_axis_c2h_tvalid !== 1'b0 || s_axis_src_tready !== 4'b0100) begin
      errors++;
      $display("FAIL bubble: grant=%0d tvalid=%b tready=%b required 2 0 0100",
               grant_id, m_axis_c2h_tvalid, s_axis_src_tready);
    end
    step();
    drive_src(2, 1'b1, 1, 1'b1);
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd2 || m_axis_c2h_tlast !== 1'b1 || m_axis_c2h_tdata !== pat(2, 1)) begin
      errors++;
      $display("FAIL bubble_end: grant=%0d tlast=%b data=%h required 2 1 %h",
               grant_id, m_axis_c2h_tlast, m_axis_c2h_tdata, pat(2, 1));
    end
    step();
    drive_src(2, 1'b0, 0, 1'b0);
    exp_total = exp_total + 32'd1;
    step();
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd0 || m_axis_c2h_tlast !== 1'b1 || pkt_total !== exp_total) begin
      errors++;
      $display("FAIL stall_src0: grant=%0d tlast=%b total=%0d required 0 1 %0d",
               grant_id, m_axis_c2h_tlast, pkt_total, exp_total);
    end
    step();
    drive_src(0, 1'b0, 0, 1'b0);
    exp_total = exp_total + 32'd1;
  endtask

  task automatic test_reset_mid();
    step();
    drive_src(0, 1'b1, 0, 1'b0);
    step();
    @(negedge user_clk);
    step();
    drive_src(0, 1'b1, 1, 1'b0);
    drive_src(3, 1'b1, 0, 1'b1);
    #2;
    user_rst = 1'b0;
    #1;
    checks++;
    if (m_axis_c2h_tvalid !== 1'b0 || m_axis_c2h_tdata !== '0 || m_axis_c2h_tlast !== 1'b0 ||
        s_axis_src_tready !== 4'b0000 || pkt_total !== 32'd0 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid: tvalid=%b tready=%b total=%0d grant=%0d required 0 0000 0 3",
               m_axis_c2h_tvalid, s_axis_src_tready, pkt_total, grant_id);
    end
    exp_total = '0;
    drive_src(0, 1'b1, 0, 1'b1);
    @(negedge user_clk);
    user_rst = 1'b1;
    step();
    @(negedge user_clk);
    checks++;
    if (grant_id !== 2'd0 || m_axis_c2h_tdata !== pat(0, 0) || s_axis_src_tready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_regrant: grant=%0d tready=%b required 0 0001", grant_id, s_axis_src_tready);
    end
    step();
    drive_src(0, 1'b0, 0, 1'b0);
    drive_src(3, 1'b0, 0, 1'b0);
    exp_total = exp_total + 32'd1;
    @(negedge user_clk);
    checks++;
    if (pkt_total !== exp_total) begin
      errors++;
      $display("FAIL reset_total: total=%0d required %0d", pkt_total, exp_total);
    end
  endtask

`ifdef C2H_ARB_IRQ_EN
  task automatic test_irq();
    do_reset();
    send_packet(0, 2, 1'b0);
    send_packet(0, 2, 1'b0);
    checks++;
    if (irq_req !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b required 0", irq_req);
    end
    send_packet(0, 2, 1'b0);
    checks++;
    if (irq_req !== 1'b1) begin
      errors++;
      $display("FAIL irq_hit: irq=%b required 1", irq_req);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (irq_req !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack: irq=%b required 0", irq_req);
    end
    for (int p = 0; p < 6; p++) send_packet(0, 2, 1'b0);
    checks++;
    if (irq_req !== 1'b1 || pkt_total !== exp_total) begin
      errors++;
      $display("FAIL irq_coalesce: irq=%b total=%0d required 1 %0d", irq_req, pkt_total, exp_total);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    send_packet(0, 2, 1'b0);
    send_packet(0, 2, 1'b0);
    send_packet(0, 2, 1'b1);
    checks++;
    if (irq_req !== 1'b1) begin
      errors++;
      $display("FAIL irq_hit_with_ack: irq=%b required 1", irq_req);
    end
  endtask
`else
  task automatic test_irq();
    do_reset();
    irq_ack = 1'b1;
    for (int p = 0; p < 3; p++) send_packet(0, 1, 1'b0);
    irq_ack = 1'b1;
    step();
    checks++;
    if (irq_req !== 1'b0 || pkt_total !== exp_total) begin
      errors++;
      $display("FAIL irq_disabled: irq=%b total=%0d required 0 %0d", irq_req, pkt_total, exp_total);
    end
    irq_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
